fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller that sequences the instruction memory. Holds the program counter, drives the memory address, and captures the returned word each cycle into a small fetch queue. It presents instructions to decode through a valid/ready handshake, redirects on taken branches, and stops fetching at a halt word. It sits between the instruction memory (combinational read) and the decode stage.

## Interface
- RESET_PC, 32'd0, PC value loaded on reset and fetched first
- QUEUE_DEPTH, 2, fetch-queue entries (2 to 8)
- HALT_WORD, 32'h0000_0000, fetched word that stops fetching (memory returns 0 past program end)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- PC  out  32  fetch address to instruction memory
- Instruction  in  32  word read combinationally from memory at PC, same cycle
- br_taken  in  1  redirect request from execute
- br_target  in  32  redirect address; bits [1:0] ignored, forced to 0
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  32  head instruction
- out_pc  out  32  address of head instruction
- halted  out  1  controller is in HALT
- fetch_cnt, stall_cnt  out  32 each  only with FETCH_PERF_CNT_EN

## Operation
- States: BOOT, RUN, HALT.
- BOOT: the one cycle after reset release. No push; PC holds RESET_PC; next state is RUN.
- RUN: push {PC, Instruction} when count < QUEUE_DEPTH, or when count == QUEUE_DEPTH and a pop occurs this cycle. On push, PC <= PC + 4, wrapping from 32'hFFFF_FFFC to 0. No push means PC holds; this counts as a stall cycle.
- Halt detect: in RUN, a push of a word equal to HALT_WORD still enqueues that word, leaves PC unchanged, and moves to HALT.
- HALT: no pushes, PC holds, queue drains normally; halted = 1.
- Pop: when out_valid && out_ready. out_valid = (count != 0). out_inst/out_pc show the head entry.
- br_taken (any state except BOOT):
  - the queue is cleared at the edge; any pop in that cycle still counts as accepted;
  - there is no push that cycle;
  - PC <= {br_target[31:2], 2'b00};
  - the next state is RUN.
- br_taken in BOOT is ignored.
- Reset values: PC = RESET_PC, queue empty, out_valid = 0, out_inst = 0, out_pc = 0, halted = 0, counters = 0, state = BOOT.
- Reset asserted mid-operation: all of the above apply immediately (asynchronous); queue contents are lost.

## Timing
- Memory read is combinational; PC is registered. One word is fetched per cycle at most.
- Fetch to out_valid latency is 1 cycle: a word pushed at edge N is visible at the head after edge N if the queue was empty.
- After reset release: BOOT at edge 1, push of RESET_PC at edge 2, out_valid = 1 after edge 2.
- Branch: br_taken sampled at edge N; out_valid = 0 after edge N; the target word is pushed at edge N+1 and is valid after it (1-cycle bubble).
- With out_ready held at 1 and no branches, throughput is one instruction per cycle.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - fetch_cnt increments on every push;
  - stall_cnt increments on every RUN cycle without a push;
  - both saturate at 32'hFFFF_FFFF and are cleared only by reset.
- FETCH_PERF_CNT_EN undefined: both ports and their logic are absent.

## Structure
- Package fetch_pkg holds:
  - the state enum fetch_state_t (BOOT, RUN, HALT);
  - the struct fetch_entry_t {pc[31:0], inst[31:0]};
  - the constant PC_STEP = 4.
- Sub-module fetch_queue: a synchronous FIFO of fetch_entry_t, QUEUE_DEPTH deep, with push, pop, clear, full, empty and count. Simultaneous push and pop when full is legal. clear has priority over push.
- fetch_ctrl contains the FSM, the PC register, the redirect logic and the optional counters.

## Test plan
- Reset release with a 7-word program at 0..24 and out_ready = 1: out_pc sequence is 0, 4, ..., 24, then 28 carrying inst 0; halted = 1; PC stays at 28.
- out_ready = 0 for 5 cycles after startup: the queue fills to 2 entries and PC holds at 8. On release, out_pc 0, 4, 8 arrive back to back with no bubble.
- br_taken with br_target = 32'h0000_0013 while the queue is full: the queue is flushed, out_valid = 0 for one cycle, and the next out_pc = 32'h10.
- From HALT, br_taken with br_target = 0: state returns to RUN and refetch starts at 0 with halted = 0.
- Assert rst mid-stream with 2 entries queued: out_valid, halted and the counters drop to 0 immediately and PC = RESET_PC. The BOOT cycle then occurs before fetching resumes.
- With FETCH_PERF_CNT_EN and the first scenario: fetch_cnt = 8 and stall_cnt = 0 at halt. A 5-cycle out_ready stall adds 3 to stall_cnt.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; clear wins over push, push+pop when full is legal.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  fetch_entry_t               i_din,
  output fetch_entry_t               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_pop) begin
        r_rd <= (r_rd == LAST_PTR) ? '0 : r_rd + 1'b1;
      end
      if (w_do_push) begin
        r_wr <= (r_wr == LAST_PTR) ? '0 : r_wr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC, fetch FSM (BOOT/RUN/HALT), branch redirect, fetch queue.
// Optional perf counters fetch_cnt/stall_cnt are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] HALT_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [1:0]  dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_halted;

  fetch_entry_t w_head;
  fetch_entry_t w_new;
  logic         w_full;
  logic         w_empty;
  logic [CW-1:0] w_q_count;
  logic         w_pop;
  logic         w_push;
  logic         w_clear;
  logic         w_in_run;
  logic         w_is_halt;
  logic         w_unused;

  assign w_in_run  = (r_state == RUN);
  assign w_pop     = !w_empty && out_ready;
  assign w_clear   = br_taken && (r_state != BOOT);
  // A full queue still accepts the fetch when decode drains the head this cycle.
  assign w_push    = w_in_run && !br_taken && (!w_full || w_pop);
  assign w_is_halt = (Instruction == HALT_WORD);
  assign w_new     = '{pc: r_pc, inst: Instruction};
  assign w_unused  = ^{br_target[1:0], w_q_count};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_din   (w_new),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_q_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        default: begin
          if (br_taken) begin
            r_state  <= RUN;
            r_pc     <= {br_target[31:2], 2'b00};
            r_halted <= 1'b0;
          end else if (w_push) begin
            if (w_is_halt) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= r_pc + PC_STEP;
            end
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_in_run && !w_push && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  assign PC        = r_pc;
  assign halted    = r_halted;
  assign dbg_state = r_state;
  assign out_valid = !w_empty;
  assign out_inst  = w_empty ? 32'd0 : w_head.inst;
  assign out_pc    = w_empty ? 32'd0 : w_head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl against a queue-based behavioural model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'd0;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  fetch_ctrl #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (DEPTH),
    .HALT_WORD   (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (PC),
    .Instruction (Instruction),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .halted      (halted),
    .dbg_state   (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // clock / memory
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign Instruction = (PC[31:8] == 24'd0) ? mem[PC[7:2]] : 32'h0;

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  // reference model: 0 = boot, 1 = run, 2 = halt
  int          m_st = 0;
  logic [31:0] m_pc = RESET_PC;
  logic [63:0] m_q[$];
  logic [31:0] m_fetch = 0;
  logic [31:0] m_stall = 0;

  logic        exp_valid  = 1'b0;
  logic [31:0] exp_pc     = RESET_PC;
  logic        exp_halted = 1'b0;
  logic [31:0] exp_fetch  = 0;
  logic [31:0] exp_stall  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd256) ? mem[a[7:2]] : 32'h0;
  endfunction

  task automatic load_prog(input int n, input bit rnd);
    for (int i = 0; i < 64; i++) begin
      if (i < n) mem[i] = rnd ? ($urandom | 32'h1) : (32'h1000_0001 + 32'(i) * 32'h100);
      else       mem[i] = 32'h0;
    end
  endtask

  task automatic model_cycle(input logic rdy, input logic br, input logic [31:0] tgt);
    logic        pop;
    logic [31:0] w;
    pop = (m_q.size() != 0) && rdy;
    if (pop) exp_q.push_back(m_q[0]);
    if (m_st == 0) begin
      m_st = 1;
    end else if (br) begin
      if (m_st == 1) m_stall++;
      m_q.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
      m_st = 1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_st == 1) begin
        if (m_q.size() < DEPTH) begin
          w = mem_word(m_pc);
          m_q.push_back({m_pc, w});
          m_fetch++;
          if (w == 32'h0) m_st = 2;
          else            m_pc = m_pc + 32'd4;
        end else begin
          m_stall++;
        end
      end
    end
  endtask

  // driver: called just after a rising edge, advances one cycle
  task automatic step(input logic rdy, input logic br, input logic [31:0] tgt);
    out_ready  = rdy;
    br_taken   = br;
    br_target  = tgt;
    exp_valid  = (m_q.size() != 0);
    exp_pc     = m_pc;
    exp_halted = (m_st == 2);
    exp_fetch  = m_fetch;
    exp_stall  = m_stall;
    model_cycle(rdy, br, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    br_taken = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pc", 64'(PC), 64'(RESET_PC));
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    m_st = 0; m_pc = RESET_PC; m_q.delete(); m_fetch = 0; m_stall = 0;
    exp_q.delete();
    exp_valid = 1'b0; exp_pc = RESET_PC; exp_halted = 1'b0; exp_fetch = 0; exp_stall = 0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // monitor: compares DUT outputs and accepted instructions away from the active edge
  always @(negedge clk) begin
    logic [63:0] e;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("pc", 64'(PC), 64'(exp_pc));
    chk("halted", 64'(halted), 64'(exp_halted));
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", 64'(fetch_cnt), 64'(exp_fetch));
    chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", {out_pc, out_inst}, 64'hXXXX_XXXX_XXXX_XXXX);
      end else begin
        e = exp_q.pop_front();
        chk("accept_pc_inst", {out_pc, out_inst}, e);
      end
    end
  end

  initial begin
    // straight-line program to halt
    load_prog(7, 1'b0);
    do_reset(2);
    repeat (14) step(1'b1, 1'b0, 32'd0);
    chk("halt_pc_28", 64'(PC), 64'd28);
    chk("halt_flag", 64'(halted), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("halt_fetch_8", 64'(fetch_cnt), 64'd8);
    chk("halt_stall_0", 64'(stall_cnt), 64'd0);
`endif

    // decode stall fills the queue, then drains back to back
    do_reset(1);
    repeat (6) step(1'b0, 1'b0, 32'd0);
    chk("stall_pc_8", 64'(PC), 64'd8);
    chk("stall_full_valid", 64'(out_valid), 64'd1);
    repeat (10) step(1'b1, 1'b0, 32'd0);

    // branch with full queue flushes and refetches from aligned target
    do_reset(1);
    repeat (6) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0013);
    chk("flush_valid_0", 64'(out_valid), 64'd0);
    step(1'b0, 1'b0, 32'd0);
    chk("target_out_pc", 64'(out_pc), 64'h10);
    repeat (8) step(1'b1, 1'b0, 32'd0);

    // redirect out of halt
    repeat (6) step(1'b1, 1'b0, 32'd0);
    chk("pre_redirect_halted", 64'(halted), 64'd1);
    step(1'b1, 1'b1, 32'd0);
    chk("redirect_unhalted", 64'(halted), 64'd0);
    repeat (5) step(1'b1, 1'b0, 32'd0);

    // asynchronous reset with entries queued
    do_reset(1);
    repeat (4) step(1'b0, 1'b0, 32'd0);
    do_reset(1);
    repeat (6) step(1'b1, 1'b0, 32'd0);

    // randomized episodes
    for (int ep = 0; ep < 25; ep++) begin
      load_prog($urandom_range(4, 60), 1'b1);
      do_reset($urandom_range(1, 3));
      for (int c = 0; c < $urandom_range(60, 120); c++) begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
             32'($urandom_range(0, 255)));
      end
    end

    step(1'b0, 1'b0, 32'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
